current_trip_monitor: RTL and testbench

- Downstream consumer of the I2C register block.
- Compares each ADC current sample against the host-programmed DDS/CW hard and monitor current limits, debounces over-limit events, and latches a trip that removes the amplifier drive enable.
- Returns an 8-bit monitor_status word and a peak-current value, which the register block exposes for host readback.

---
 rtl/current_trip_monitor_pkg.sv | 25 ++
 rtl/current_trip_monitor_if.sv | 31 +++
 rtl/current_trip_monitor_over_limit_qualifier.sv | 37 +++
 rtl/current_trip_monitor.sv | 131 +++++++++++++
 tb/tb_current_trip_monitor.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/current_trip_monitor_pkg.sv
// Shared types and constants for the current trip monitor: FSM states,
// monitor_status bit positions and default debounce/blanking settings.
package current_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ARMED,
    ST_PENDING,
    ST_TRIPPED
  } state_e;

  localparam int MS_TRIP        = 0;
  localparam int MS_WARN_STICKY = 1;
  localparam int MS_WARN_LIVE   = 2;
  localparam int MS_OVER_HARD   = 3;
  localparam int MS_ARMED       = 4;
  localparam int MS_BLANKING    = 5;
  localparam int MS_TRIP_MODE   = 6;

  localparam int DEF_TRIP_COUNT   = 4;
  localparam int DEF_WARN_COUNT   = 2;
  localparam int DEF_BLANK_CYCLES = 1000;

endpackage

// File: rtl/current_trip_monitor_if.sv
// Sample/limit/control inputs and status outputs between the register
// block (master) and the current trip monitor (slave).
interface current_trip_monitor_if;
  logic [15:0] adc_current_data;
  logic        adc_vld;
  logic        mode_cw;
  logic        enable;
  logic        clear;
  logic [15:0] dds_current_limit;
  logic [15:0] cw_current_limit;
  logic [15:0] dds_mon_current_limit;
  logic [15:0] cw_mon_current_limit;
  logic        drive_en;
  logic        trip;
  logic [7:0]  monitor_status;
  logic [15:0] peak_current;

  modport master (
    output adc_current_data, adc_vld, mode_cw, enable, clear,
           dds_current_limit, cw_current_limit,
           dds_mon_current_limit, cw_mon_current_limit,
    input  drive_en, trip, monitor_status, peak_current
  );

  modport slave (
    input  adc_current_data, adc_vld, mode_cw, enable, clear,
           dds_current_limit, cw_current_limit,
           dds_mon_current_limit, cw_mon_current_limit,
    output drive_en, trip, monitor_status, peak_current
  );
endinterface

// File: rtl/current_trip_monitor_over_limit_qualifier.sv
// Strictly-greater limit compare with a saturating run counter of
// consecutive over-limit samples.
module over_limit_qualifier (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] sample,
  input  logic        vld,
  input  logic [15:0] limit,
  input  logic [7:0]  threshold,
  input  logic        flush,
  output logic        over,
  output logic        at_thresh_next
);

  logic [7:0] count_q, count_d;

  assign over = (sample > limit);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (vld) begin
      if (!over)                       count_d = '0;
      else if (count_q != threshold)   count_d = count_q + 8'd1;
    end
  end

  // Look-ahead flag lets the FSM trip on the edge that consumes the sample.
  assign at_thresh_next = (count_d == threshold);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/current_trip_monitor.sv
// Current trip monitor: blanking after arming, debounced hard-limit trip,
// debounced warning, peak tracking and a registered status word.
module current_trip_monitor
  import current_mon_pkg::*;
#(
  parameter int TRIP_COUNT   = DEF_TRIP_COUNT,
  parameter int WARN_COUNT   = DEF_WARN_COUNT,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BLANK_W      = 16
) (
  input logic                   clk,
  input logic                   rstn,
  current_trip_monitor_if.slave mon
);

  localparam logic [BLANK_W-1:0] BLANK_LAST =
    BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic                en_prev_q, trip_mode_q, trip_mode_d;
  logic                last_over_q, last_over_d, sticky_q, sticky_d;
  logic                drive_en_q, drive_en_d, trip_q, trip_d;
  logic [15:0]         peak_q, peak_d;
  logic [7:0]          status_q, status_d;
  logic [15:0]         hard_limit, mon_limit;
  logic                flush, hard_over, hard_at, warn_over, warn_at;
  logic                hard_reach, armed_d, warn_live_d;

  assign hard_limit = mon.mode_cw ? mon.cw_current_limit     : mon.dds_current_limit;
  assign mon_limit  = mon.mode_cw ? mon.cw_mon_current_limit : mon.dds_mon_current_limit;
  assign flush      = (state_q == ST_IDLE) || (state_q == ST_BLANK) || (state_q == ST_TRIPPED);

  over_limit_qualifier u_hard (
    .clk(clk), .rstn(rstn), .sample(mon.adc_current_data), .vld(mon.adc_vld),
    .limit(hard_limit), .threshold(8'(TRIP_COUNT)), .flush(flush),
    .over(hard_over), .at_thresh_next(hard_at)
  );

  over_limit_qualifier u_warn (
    .clk(clk), .rstn(rstn), .sample(mon.adc_current_data), .vld(mon.adc_vld),
    .limit(mon_limit), .threshold(8'(WARN_COUNT)), .flush(flush),
    .over(warn_over), .at_thresh_next(warn_at)
  );

  assign hard_reach = mon.adc_vld && hard_over && hard_at;

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = '0;
    case (state_q)
      ST_IDLE:
        if (mon.enable && !en_prev_q)
          state_d = (BLANK_CYCLES == 0) ? ST_ARMED : ST_BLANK;
      ST_BLANK:
        if (!mon.enable)                 state_d = ST_IDLE;
        else if (blank_cnt_q == BLANK_LAST) state_d = ST_ARMED;
        else                             blank_cnt_d = blank_cnt_q + 1'b1;
      ST_ARMED:
        if (!mon.enable)                 state_d = ST_IDLE;
        else if (mon.adc_vld && hard_over)
          state_d = hard_reach ? ST_TRIPPED : ST_PENDING;
      ST_PENDING:
        if (!mon.enable)                 state_d = ST_IDLE;
        else if (mon.adc_vld) begin
          if (!hard_over)                state_d = ST_ARMED;
          else if (hard_reach)           state_d = ST_TRIPPED;
        end
      ST_TRIPPED:
        if (mon.clear)                   state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    trip_mode_d = trip_mode_q;
    if ((state_d == ST_TRIPPED) && (state_q != ST_TRIPPED))
      trip_mode_d = mon.mode_cw;
    last_over_d = mon.adc_vld ? hard_over : last_over_q;
    armed_d     = (state_d == ST_ARMED) || (state_d == ST_PENDING);
    warn_live_d = armed_d && warn_at;
    sticky_d    = (sticky_q && !mon.clear) || warn_live_d;
    if (mon.adc_vld)
      peak_d = (mon.clear || (mon.adc_current_data > peak_q)) ? mon.adc_current_data : peak_q;
    else
      peak_d = mon.clear ? 16'h0000 : peak_q;
    trip_d     = (state_d == ST_TRIPPED);
    drive_en_d = (state_d == ST_BLANK) || armed_d;
    status_d                 = '0;
    status_d[MS_TRIP]        = trip_d;
    status_d[MS_WARN_STICKY] = sticky_d;
    status_d[MS_WARN_LIVE]   = warn_live_d;
    status_d[MS_OVER_HARD]   = last_over_d;
    status_d[MS_ARMED]       = armed_d;
    status_d[MS_BLANKING]    = (state_d == ST_BLANK);
    status_d[MS_TRIP_MODE]   = trip_d && trip_mode_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      blank_cnt_q <= '0;
      en_prev_q   <= 1'b0;
      trip_mode_q <= 1'b0;
      last_over_q <= 1'b0;
      sticky_q    <= 1'b0;
      peak_q      <= '0;
      status_q    <= '0;
      drive_en_q  <= 1'b0;
      trip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      en_prev_q   <= mon.enable;
      trip_mode_q <= trip_mode_d;
      last_over_q <= last_over_d;
      sticky_q    <= sticky_d;
      peak_q      <= peak_d;
      status_q    <= status_d;
      drive_en_q  <= drive_en_d;
      trip_q      <= trip_d;
    end
  end

  assign mon.drive_en       = drive_en_q;
  assign mon.trip           = trip_q;
  assign mon.monitor_status = status_q;
  assign mon.peak_current   = peak_q;

endmodule

// File: tb/tb_current_trip_monitor.sv
// Self-checking bench for current_trip_monitor: directed scenarios plus a
// randomized stream compared against a behavioural model.
module tb_current_trip_monitor;

  localparam int TC    = 4;
  localparam int WC    = 2;
  localparam int BLANK = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  current_trip_monitor_if bus();

  current_trip_monitor #(
    .TRIP_COUNT(TC), .WARN_COUNT(WC), .BLANK_CYCLES(BLANK), .BLANK_W(16)
  ) dut (
    .clk(clk), .rstn(rstn), .mon(bus)
  );

  always #5 clk = ~clk;

  // Model: "active" means the drive is on (blanking or comparing);
  // blank_left counts remaining blanking cycles; runs are consecutive-over lengths.
  bit          m_active, m_tripped, m_prev_en, m_sticky, m_live, m_last_over, m_tmode;
  int          m_blank, m_hrun, m_wrun;
  int unsigned m_peak;

  task automatic model_reset();
    m_active = 0; m_tripped = 0; m_prev_en = 0; m_sticky = 0; m_live = 0;
    m_last_over = 0; m_tmode = 0; m_blank = 0; m_hrun = 0; m_wrun = 0; m_peak = 0;
  endtask

  task automatic model_step();
    int unsigned hl, ml, s;
    bit v, ovh, ovm, cmp;
    int hrun, wrun;
    hl = bus.mode_cw ? bus.cw_current_limit : bus.dds_current_limit;
    ml = bus.mode_cw ? bus.cw_mon_current_limit : bus.dds_mon_current_limit;
    s  = bus.adc_current_data;
    v  = bus.adc_vld;
    ovh = v && (s > hl);
    ovm = v && (s > ml);
    cmp = m_active && (m_blank == 0);
    hrun = !cmp ? 0 : !v ? m_hrun : ovh ? ((m_hrun < TC) ? m_hrun + 1 : TC) : 0;
    wrun = !cmp ? 0 : !v ? m_wrun : ovm ? ((m_wrun < WC) ? m_wrun + 1 : WC) : 0;
    if (m_tripped) begin
      if (bus.clear) m_tripped = 0;
    end else if (m_active) begin
      if (!bus.enable) begin
        m_active = 0; m_blank = 0;
      end else if (m_blank > 0) begin
        m_blank--;
      end else if (ovh && hrun == TC) begin
        m_tripped = 1; m_active = 0; m_tmode = bus.mode_cw;
      end
    end else if (bus.enable && !m_prev_en) begin
      m_active = 1; m_blank = BLANK;
    end
    m_hrun = hrun;
    m_wrun = wrun;
    m_live = m_active && (m_blank == 0) && (wrun == WC);
    m_sticky = (m_sticky && !bus.clear) || m_live;
    if (v) m_peak = bus.clear ? s : ((s > m_peak) ? s : m_peak);
    else if (bus.clear) m_peak = 0;
    if (v) m_last_over = ovh;
    m_prev_en = bus.enable;
  endtask

  function automatic logic [25:0] exp_vec();
    logic [7:0] st;
    st = {1'b0, m_tripped && m_tmode, m_active && (m_blank > 0), m_active && (m_blank == 0),
          m_last_over, m_live, m_sticky, m_tripped};
    return {m_active, m_tripped, st, m_peak[15:0]};
  endfunction

  task automatic tick(input logic v, input logic [15:0] s, input logic c);
    bus.adc_vld = v; bus.adc_current_data = s; bus.clear = c;
    model_step();
    @(posedge clk); #1;
    bus.adc_vld = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic rearm();
    tick(0, 16'h0, 1);
    bus.enable = 1'b0; tick(0, 16'h0, 0);
    bus.enable = 1'b1; tick(0, 16'h0, 0);
    for (int i = 0; i < BLANK; i++) tick(0, 16'h0, 0);
  endtask

  task automatic test_reset();
    bus.adc_vld = 0; bus.adc_current_data = 0; bus.clear = 0; bus.mode_cw = 0; bus.enable = 0;
    bus.dds_current_limit = 16'h8000; bus.dds_mon_current_limit = 16'hFFFF;
    bus.cw_current_limit = 16'hFFFF;  bus.cw_mon_current_limit = 16'hFFFF;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== 26'd0) begin
      errors++; $display("FAIL reset: got %h want 0", {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current});
    end
    rstn = 1'b1;
  endtask

  task automatic test_arm_blank();
    tick(0, 16'h0, 0);
    bus.enable = 1'b1;
    tick(0, 16'h0, 0);
    checks++;
    if (bus.monitor_status[5] !== 1'b1 || bus.drive_en !== 1'b1) begin
      errors++; $display("FAIL blank_start: status %h drive_en %b want blanking and drive", bus.monitor_status, bus.drive_en);
    end
    for (int i = 0; i < BLANK - 1; i++) begin
      tick(1, 16'h9000, 0);
      checks++;
      if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec() || bus.monitor_status[5] !== 1'b1) begin
        errors++; $display("FAIL blank_cycle%0d: got %h want %h", i, {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current}, exp_vec());
      end
    end
    tick(0, 16'h0, 0);
    checks++;
    if (bus.monitor_status[5:4] !== 2'b01 || bus.trip !== 1'b0 || bus.peak_current !== 16'h9000) begin
      errors++; $display("FAIL blank_end: status %h trip %b peak %h want armed, no trip, peak 9000", bus.monitor_status, bus.trip, bus.peak_current);
    end
  endtask

  task automatic test_debounced_trip();
    for (int i = 0; i < TC; i++) begin
      tick(1, 16'h8001, 0);
      checks++;
      if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec()) begin
        errors++; $display("FAIL trip_seq%0d: got %h want %h", i, {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current}, exp_vec());
      end
    end
    checks++;
    if (bus.trip !== 1'b1 || bus.drive_en !== 1'b0 || bus.monitor_status[0] !== 1'b1) begin
      errors++; $display("FAIL trip_latency: trip %b drive_en %b status %h want tripped", bus.trip, bus.drive_en, bus.monitor_status);
    end
  endtask

  task automatic test_clear_rearm();
    tick(0, 16'h0, 1);
    checks++;
    if (bus.trip !== 1'b0 || bus.peak_current !== 16'h0 || bus.drive_en !== 1'b0) begin
      errors++; $display("FAIL clear: trip %b peak %h drive_en %b want 0 0 0", bus.trip, bus.peak_current, bus.drive_en);
    end
    tick(0, 16'h0, 0);
    checks++;
    if (bus.drive_en !== 1'b0) begin
      errors++; $display("FAIL no_rearm_held: drive_en %b want 0", bus.drive_en);
    end
    bus.enable = 1'b0; tick(0, 16'h0, 0);
    bus.enable = 1'b1; tick(0, 16'h0, 0);
    checks++;
    if (bus.monitor_status[5] !== 1'b1 || bus.drive_en !== 1'b1) begin
      errors++; $display("FAIL rearm_blank: status %h drive_en %b want blanking", bus.monitor_status, bus.drive_en);
    end
    for (int i = 0; i < BLANK; i++) tick(0, 16'h0, 0);
    checks++;
    if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec() || bus.monitor_status[4] !== 1'b1) begin
      errors++; $display("FAIL rearm_armed: got %h want %h", {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current}, exp_vec());
    end
  endtask

  task automatic test_debounce_reset();
    logic [15:0] seq [7];
    seq = '{16'h8001, 16'h8001, 16'h8001, 16'h8000, 16'h8001, 16'h8001, 16'h8001};
    for (int i = 0; i < 7; i++) begin
      tick(1, seq[i], 0);
      checks++;
      if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec() || bus.trip !== 1'b0 || bus.monitor_status[4] !== 1'b1) begin
        errors++; $display("FAIL debounce%0d: got %h want %h and no trip", i, {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current}, exp_vec());
      end
    end
  endtask

  task automatic test_warning_mode();
    bus.mode_cw = 1'b1; bus.cw_mon_current_limit = 16'h4000; bus.cw_current_limit = 16'h8000;
    tick(0, 16'h0, 1);
    checks++;
    if (bus.monitor_status[1] !== 1'b0) begin
      errors++; $display("FAIL warn_pre: sticky %b want 0", bus.monitor_status[1]);
    end
    tick(1, 16'h4001, 0);
    tick(1, 16'h4001, 0);
    checks++;
    if (bus.monitor_status[2:1] !== 2'b11 || {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec()) begin
      errors++; $display("FAIL warn_set: status %h want live and sticky (model %h)", bus.monitor_status, exp_vec());
    end
    tick(1, 16'h3000, 0);
    checks++;
    if (bus.monitor_status[2:1] !== 2'b01) begin
      errors++; $display("FAIL warn_drop: status %h want live 0 sticky 1", bus.monitor_status);
    end
  endtask

  task automatic test_clear_trip_same_cycle();
    bus.mode_cw = 1'b0;
    for (int i = 0; i < TC - 1; i++) tick(1, 16'h8001, 0);
    tick(1, 16'h8001, 1);
    checks++;
    if (bus.trip !== 1'b1 || bus.peak_current !== 16'h8001 || bus.monitor_status[1] !== 1'b0 ||
        {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec()) begin
      errors++; $display("FAIL clear_vs_trip: trip %b peak %h status %h want trip, peak 8001, sticky 0", bus.trip, bus.peak_current, bus.monitor_status);
    end
    rearm();
  endtask

  task automatic test_enable_drop();
    tick(1, 16'h8001, 0);
    checks++;
    if (bus.monitor_status[4] !== 1'b1 || bus.trip !== 1'b0) begin
      errors++; $display("FAIL pending: status %h want armed", bus.monitor_status);
    end
    bus.enable = 1'b0;
    tick(0, 16'h0, 0);
    checks++;
    if (bus.drive_en !== 1'b0 || bus.monitor_status[4] !== 1'b0 || bus.trip !== 1'b0) begin
      errors++; $display("FAIL enable_drop: drive_en %b status %h want idle", bus.drive_en, bus.monitor_status);
    end
    bus.enable = 1'b1;
    tick(0, 16'h0, 0);
    checks++;
    if (bus.monitor_status[5] !== 1'b1) begin
      errors++; $display("FAIL enable_rise: status %h want blanking", bus.monitor_status);
    end
    rearm();
  endtask

  task automatic test_random();
    logic [15:0] s, lim;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 39) == 0) bus.mode_cw = ~bus.mode_cw;
      if ($urandom_range(0, 79) == 0) begin
        bus.dds_current_limit     = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(32'h7000 + $urandom_range(0, 32'h2000));
        bus.cw_current_limit      = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(32'h7000 + $urandom_range(0, 32'h2000));
        bus.dds_mon_current_limit = 16'(32'h5000 + $urandom_range(0, 32'h2000));
        bus.cw_mon_current_limit  = 16'(32'h5000 + $urandom_range(0, 32'h2000));
      end
      lim = bus.mode_cw ? bus.cw_current_limit : bus.dds_current_limit;
      case ($urandom_range(0, 3))
        0: s = lim;
        1: s = lim + 16'd1;
        2: s = lim - 16'd1;
        default: s = 16'($urandom_range(0, 32'hFFFF));
      endcase
      tick($urandom_range(0, 3) != 0, s, $urandom_range(0, 29) == 0);
      checks++;
      if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== exp_vec()) begin
        errors++; $display("FAIL random%0d: got %h want %h", n, {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_while_tripped();
    bus.mode_cw = 1'b1; bus.cw_current_limit = 16'h8000; bus.enable = 1'b1;
    bus.dds_current_limit = 16'h8000;
    rearm();
    for (int i = 0; i < TC; i++) tick(1, 16'h8001, 0);
    checks++;
    if (bus.trip !== 1'b1 || bus.monitor_status[6] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_trip: trip %b status %h want tripped in cw", bus.trip, bus.monitor_status);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current} !== 26'd0) begin
      errors++; $display("FAIL async_reset: got %h want 0", {bus.drive_en, bus.trip, bus.monitor_status, bus.peak_current});
    end
    model_reset();
    bus.enable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arm_blank();
    test_debounced_trip();
    test_clear_rearm();
    test_debounce_reset();
    test_warning_mode();
    test_clear_trip_same_cycle();
    test_enable_drop();
    test_random();
    test_reset_while_tripped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
